// File: rtl/hazard_controller.sv
// hazard_controller
//
// Hazard scheduler for the 5-stage MIPS core. It compares the instruction in
// ID against the producers in EX and MEM. Each cycle it decides whether the
// front end advances, stalls with a bubble into ID/EX, or flushes IF/ID after
// a taken branch or jump. It also tracks occupancy of the multi-cycle
// multiply/divide unit and counts stall cycles.
//
// Parameters
//   MDU_CYCLES  cycles a mult/div keeps the MDU occupied (>= 2)
//   CNT_WIDTH   width of the stall performance counter
//
// Ports
//   i_clk, i_rst                  clock (rising edge), synchronous active-high reset
//   i_id_rs, i_id_rt              source registers of the ID instruction
//   i_id_use_rs, i_id_use_rt      ID instruction actually reads rs / rt
//   i_id_branch                   ID instruction compares operands in ID
//   i_id_jump                     ID instruction is an unconditional jump
//   i_branch_taken                ID branch comparator result
//   i_id_mdu_start                ID instruction starts a mult/div
//   i_id_mdu_access               ID instruction touches HI/LO
//   i_ex_memread, i_ex_regwrite   EX instruction is a load / writes a register
//   i_ex_rd                       EX destination register
//   i_mem_memread, i_mem_rd       MEM instruction is a load, and its destination
//   o_pc_write, o_ifid_write      front-end enables
//   o_ifid_flush                  clear IF/ID to nop
//   o_idex_bubble                 load nop into ID/EX
//   o_mdu_busy                    MDU occupied
//   o_stall_count                 stall cycles since reset (wraps)

module hazard_controller #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [4:0]           i_id_rs,
    input  logic [4:0]           i_id_rt,
    input  logic                 i_id_use_rs,
    input  logic                 i_id_use_rt,
    input  logic                 i_id_branch,
    input  logic                 i_id_jump,
    input  logic                 i_branch_taken,
    input  logic                 i_id_mdu_start,
    input  logic                 i_id_mdu_access,
    input  logic                 i_ex_memread,
    input  logic                 i_ex_regwrite,
    input  logic [4:0]           i_ex_rd,
    input  logic                 i_mem_memread,
    input  logic [4:0]           i_mem_rd,
    output logic                 o_pc_write,
    output logic                 o_ifid_write,
    output logic                 o_ifid_flush,
    output logic                 o_idex_bubble,
    output logic                 o_mdu_busy,
    output logic [CNT_WIDTH-1:0] o_stall_count
);

    localparam int CW = $clog2(MDU_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_CYCLES - 1);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t           state;
    logic [CW-1:0]        cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic br_ex;
    logic br_mem;
    logic mdu_hold;
    logic stall;
    logic flush;

    // Register 0 is hardwired to zero, so a write to it never creates a hazard.
    function automatic logic reg_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_src & (src == dst) & (dst != 5'd0);
    endfunction

    always_comb begin
        match_ex  = reg_match(i_id_use_rs, i_id_rs, i_ex_rd)
                  | reg_match(i_id_use_rt, i_id_rt, i_ex_rd);
        match_mem = reg_match(i_id_use_rs, i_id_rs, i_mem_rd)
                  | reg_match(i_id_use_rt, i_id_rt, i_mem_rd);

        load_use = i_ex_memread & match_ex;
        // Branches resolve in ID, so they also wait on ALU results still in
        // EX and on load data that is only available after MEM.
        br_ex    = i_id_branch & i_ex_regwrite & match_ex;
        br_mem   = i_id_branch & i_mem_memread & match_mem;
        mdu_hold = (state == BUSY) & i_id_mdu_access;

        stall = load_use | br_ex | br_mem | mdu_hold;
        // A pending operand makes the comparator result meaningless, so a
        // stall suppresses the flush.
        flush = (i_branch_taken | i_id_jump) & ~stall;
    end

    always_comb begin
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        if (i_rst) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
        end else if (stall) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_idex_bubble = 1'b1;
        end else if (flush) begin
            o_ifid_flush  = 1'b1;
        end
    end

    // Reset forces the visible status low in the reset cycle itself, before
    // the registers are cleared at the edge.
    assign o_mdu_busy    = (state == BUSY) & ~i_rst;
    assign o_stall_count = i_rst ? '0 : stall_cnt;

    // MDU occupancy FSM and stall counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                RUN: begin
                    // A start that coincides with any stall is not issued.
                    if (i_id_mdu_start & ~stall) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard scheduler for the 5-stage MIPS core. It watches the ID stage (where the immediate extender and branch comparator sit) against the EX and MEM stages. It decides each cycle whether the front end advances, stalls with a bubble into ID/EX, or flushes IF/ID on a taken branch or jump. It also sequences the multi-cycle multiply/divide unit: a busy counter stalls dependent HI/LO instructions until the unit is free, and a performance counter records stall cycles.

## Interface
- MDU_CYCLES, 32, cycles a mult/div occupies the MDU (≥2)
- CNT_WIDTH, 32, width of stall performance counter

- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_id_rs, i_id_rt  in  5 each  source register numbers of the instruction in ID
- i_id_use_rs, i_id_use_rt  in  1 each  ID instruction reads rs / rt
- i_id_branch  in  1  ID instruction compares operands in ID (beq, bne, jr, jalr)
- i_id_jump  in  1  ID instruction is an unconditional jump (j, jal, jr, jalr)
- i_branch_taken  in  1  ID branch comparator result (taken)
- i_id_mdu_start  in  1  ID instruction is mult/multu/div/divu
- i_id_mdu_access  in  1  ID instruction touches HI/LO (mfhi, mflo, mthi, mtlo, mult*, div*)
- i_ex_memread, i_ex_regwrite  in  1 each  EX-stage instruction is a load / writes a register
- i_ex_rd  in  5  EX-stage destination register
- i_mem_memread  in  1  MEM-stage instruction is a load
- i_mem_rd  in  5  MEM-stage destination register
- o_pc_write  out  1  PC update enable
- o_ifid_write  out  1  IF/ID register enable
- o_ifid_flush  out  1  clear IF/ID to nop
- o_idex_bubble  out  1  load nop into ID/EX
- o_mdu_busy  out  1  MDU occupied
- o_stall_count  out  CNT_WIDTH  cycles with stall asserted since reset

## Operation
- Match rules: match_rs = i_id_use_rs & (i_id_rs == X) & (X != 0). match_rt is the same with rt. Register 0 never causes a hazard.
- A stall condition is any of the following:
  - load_use: i_ex_memread & (match_rs|match_rt on i_ex_rd).
  - br_ex: i_id_branch & i_ex_regwrite & match on i_ex_rd.
  - br_mem: i_id_branch & i_mem_memread & match on i_mem_rd.
  - mdu_hold: state BUSY & i_id_mdu_access.
- stall = OR of the above.
- On stall: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=0.
- Flush: (i_branch_taken | i_id_jump) & ~stall → o_ifid_flush=1. PC and IF/ID stay enabled.
- Stall beats flush: the branch outcome is invalid while its operands are pending.
- Otherwise o_pc_write=1, o_ifid_write=1, o_idex_bubble=0, o_ifid_flush=0.
- MDU state machine, states RUN and BUSY, with a down-counter cnt of width clog2(MDU_CYCLES):
  - RUN: i_id_mdu_start & ~stall → BUSY, cnt ← MDU_CYCLES-1.
  - BUSY: cnt ← cnt-1 each cycle. At cnt==0 → RUN.
  - A mult/div in ID while BUSY stalls through mdu_hold. It issues in the cycle after the FSM returns to RUN.
  - o_mdu_busy = (state==BUSY).
- o_stall_count increments by 1 on each clock edge where stall=1 and i_rst=0. It wraps modulo 2^CNT_WIDTH.

## Timing
- Stall, flush and bubble outputs are combinational from the current inputs and registered state, so they are valid in the same cycle.
- FSM, cnt and o_stall_count update on the rising edge of i_clk.
- Load-use stall lasts 1 cycle.
- Branch after ALU producer: 1 cycle.
- Branch after load: 2 cycles (br_ex on the first cycle, br_mem on the second).
- An MDU op issued at edge N holds o_mdu_busy=1 for exactly MDU_CYCLES cycles, after edges N … N+MDU_CYCLES-1.
- While i_rst=1, outputs are forced and registered state is cleared:
  - o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, o_ifid_flush=1.
  - o_mdu_busy=0, o_stall_count=0.
  - Next state is RUN, cnt=0.
- Reset mid-BUSY aborts the operation. o_mdu_busy=0 on the first cycle after reset deasserts.
- Simultaneous mdu_start and another stall: the start is not accepted and the FSM stays in RUN.

## Test plan
- Load-use: EX holds lw $8 (i_ex_memread=1, rd=8), ID uses rs=8 → one cycle with o_pc_write=0, o_idex_bubble=1, then advance; o_stall_count=1.
- Register 0: the same load with rd=0, ID rs=0 → no stall, o_pc_write=1.
- Branch after load: beq $9 in ID, lw $9 in EX → stall 2 consecutive cycles (br_ex then br_mem); i_branch_taken=1 meanwhile gives o_ifid_flush=0 until the 3rd cycle, then o_ifid_flush=1.
- MDU: MDU_CYCLES=4, issue div, then mflo in ID next cycle → o_mdu_busy high 4 cycles, mflo stalled 4 cycles, issues on the 5th; o_stall_count=4.
- Reset mid-BUSY: assert i_rst at cnt=2 for one cycle → o_mdu_busy=0 and o_stall_count=0 afterwards; mflo proceeds immediately.
- Jump: j in ID, no hazards → o_ifid_flush=1 for 1 cycle, o_pc_write=1, o_idex_bubble=0.
